// File: rtl/control_pkg.sv
// Shared encodings for the 16-bit CPU main decoder: opcodes, R-type function
// codes, ALU operations, branch kinds and the raw decoded-control bundle.
package control_pkg;

  localparam int unsigned ALU_CONTROL_WIDTH    = 4;
  localparam int unsigned BRANCH_CONTROL_WIDTH = 2;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'b0000,
    OP_JMP   = 4'b0001,
    OP_BGT   = 4'b0100,
    OP_BLT   = 4'b0101,
    OP_BEQ   = 4'b0110,
    OP_LW    = 4'b1000,
    OP_SW    = 4'b1011,
    OP_ADDI  = 4'b1100,
    OP_HLT   = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    FN_MUL  = 4'b0001,
    FN_DIV  = 4'b0010,
    FN_ROTL = 4'b1000,
    FN_ROTR = 4'b1001,
    FN_SHL  = 4'b1010,
    FN_SHR  = 4'b1011,
    FN_OR   = 4'b1100,
    FN_AND  = 4'b1101,
    FN_SUB  = 4'b1110,
    FN_ADD  = 4'b1111
  } func_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_MUL  = 4'b0100,
    ALU_DIV  = 4'b0101,
    ALU_ROTL = 4'b0110,
    ALU_ROTR = 4'b0111,
    ALU_SHL  = 4'b1000,
    ALU_SHR  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_LT   = 2'b10,
    BR_GT   = 2'b11
  } branch_e;

  typedef struct packed {
    logic    jump;
    logic    hlt;
    logic    write_reg;
    logic    write_r0;
    logic    mem_wrt;
    logic    alu_a_src;
    logic    alu_b_src;
    logic    reg_wr_src;
    branch_e branch;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational instruction decode: opcode/func -> raw datapath
// controls plus an illegal-instruction flag. No exception or halt gating here.
module control_decoder
  import control_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] func_code,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.write_reg = 1'b1;
        case (func_code)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_MUL: begin
            ctrl.alu_op   = ALU_MUL;
            ctrl.write_r0 = 1'b1;
          end
          FN_DIV: begin
            ctrl.alu_op   = ALU_DIV;
            ctrl.write_r0 = 1'b1;
          end
          FN_ROTL: ctrl.alu_op = ALU_ROTL;
          FN_ROTR: ctrl.alu_op = ALU_ROTR;
          FN_SHL:  ctrl.alu_op = ALU_SHL;
          FN_SHR:  ctrl.alu_op = ALU_SHR;
          default: begin
            ctrl.write_reg = 1'b0;
            ctrl.illegal   = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.write_reg  = 1'b1;
        ctrl.alu_b_src  = 1'b1;
        ctrl.reg_wr_src = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_wrt   = 1'b1;
        ctrl.alu_b_src = 1'b1;
      end
      OP_ADDI: begin
        ctrl.write_reg = 1'b1;
        ctrl.alu_b_src = 1'b1;
      end
      // Branches compare op1 against R0, so the A operand comes from R0.
      OP_BGT: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.alu_a_src = 1'b1;
        ctrl.branch    = BR_GT;
      end
      OP_BLT: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.alu_a_src = 1'b1;
        ctrl.branch    = BR_LT;
      end
      OP_BEQ: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.alu_a_src = 1'b1;
        ctrl.branch    = BR_EQ;
      end
      OP_JMP:  ctrl.jump    = 1'b1;
      OP_HLT:  ctrl.hlt     = 1'b1;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main control unit: decode plus exception merge, sticky halt and gating of
// every state-changing control while stopped or in reset.
module control_unit
  import control_pkg::*;
#(
  parameter int unsigned ALU_CONTROL_WIDTH    = control_pkg::ALU_CONTROL_WIDTH,
  parameter int unsigned BRANCH_CONTROL_WIDTH = control_pkg::BRANCH_CONTROL_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [3:0]                      opcode,
  input  logic [3:0]                      func_code,
  input  logic                            inst_memory_exception,
  input  logic                            alu_exception,
  input  logic                            data_memory_exception,
  output logic                            jump,
  output logic                            halt,
  output logic                            write_reg,
  output logic                            write_r0,
  output logic [BRANCH_CONTROL_WIDTH-1:0] branch,
  output logic                            mem_wrt,
  output logic [ALU_CONTROL_WIDTH-1:0]    alu_control,
  output logic                            alu_a_src,
  output logic                            alu_b_src,
  output logic                            reg_wr_src
);

  ctrl_t raw;
  logic  stop;
  logic  block;
  logic  halted_q;

  control_decoder u_decoder (
    .opcode    (opcode),
    .func_code (func_code),
    .ctrl      (raw)
  );

  assign stop = raw.illegal | raw.hlt | inst_memory_exception
              | alu_exception | data_memory_exception;

  always_ff @(posedge clk) begin
    if (!rst_n)
      halted_q <= 1'b0;
    else if (stop)
      halted_q <= 1'b1;
  end

  // Reset suppresses halt itself; block covers every reason to kill enables.
  assign block = !rst_n || halted_q || stop;

  always_comb begin
    halt        = rst_n && (halted_q || stop);
    jump        = raw.jump      && !block;
    write_reg   = raw.write_reg && !block;
    write_r0    = raw.write_r0  && !block;
    mem_wrt     = raw.mem_wrt   && !block;
    branch      = block ? '0 : BRANCH_CONTROL_WIDTH'(raw.branch);
    alu_control = ALU_CONTROL_WIDTH'(raw.alu_op);
    alu_a_src   = raw.alu_a_src;
    alu_b_src   = raw.alu_b_src;
    reg_wr_src  = raw.reg_wr_src;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: decode table, illegal and
// exception stops, sticky halt and reset priority.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [3:0] func_code;
  logic       inst_memory_exception;
  logic       alu_exception;
  logic       data_memory_exception;
  logic       jump, halt, write_reg, write_r0, mem_wrt;
  logic [1:0] branch;
  logic [3:0] alu_control;
  logic       alu_a_src, alu_b_src, reg_wr_src;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  control_unit #(
    .ALU_CONTROL_WIDTH    (4),
    .BRANCH_CONTROL_WIDTH (2)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .opcode                (opcode),
    .func_code             (func_code),
    .inst_memory_exception (inst_memory_exception),
    .alu_exception         (alu_exception),
    .data_memory_exception (data_memory_exception),
    .jump                  (jump),
    .halt                  (halt),
    .write_reg             (write_reg),
    .write_r0              (write_r0),
    .branch                (branch),
    .mem_wrt               (mem_wrt),
    .alu_control           (alu_control),
    .alu_a_src             (alu_a_src),
    .alu_b_src             (alu_b_src),
    .reg_wr_src            (reg_wr_src)
  );

  // Packed view: jump halt wr wr0 br[1:0] mw alu[3:0] asrc bsrc rsrc
  function automatic logic [13:0] v(input logic j, input logic h,
                                    input logic wr, input logic wr0,
                                    input logic [1:0] br, input logic mw,
                                    input logic [3:0] alu, input logic as_,
                                    input logic bs, input logic rs);
    return {j, h, wr, wr0, br, mw, alu, as_, bs, rs};
  endfunction

  // Applies inputs just after the falling edge and samples 1 time unit later,
  // well away from the rising edge; one rising edge separates successive steps.
  task automatic step(input string tag, input logic rst, input logic [3:0] op,
                      input logic [3:0] fn, input logic [2:0] exc,
                      input logic [13:0] expected);
    logic [13:0] observed;
    @(negedge clk);
    rst_n                 = rst;
    opcode                = op;
    func_code             = fn;
    inst_memory_exception = exc[2];
    alu_exception         = exc[1];
    data_memory_exception = exc[0];
    #1;
    observed = {jump, halt, write_reg, write_r0, branch, mem_wrt,
                alu_control, alu_a_src, alu_b_src, reg_wr_src};
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; func_code = '0;
    inst_memory_exception = 1'b0; alu_exception = 1'b0; data_memory_exception = 1'b0;

    step("reset_add",  0, 4'b0000, 4'b1111, 3'b000, v(0,0,0,0,2'b00,0,4'b0000,0,0,0));
    step("r_add",      1, 4'b0000, 4'b1111, 3'b000, v(0,0,1,0,2'b00,0,4'b0000,0,0,0));
    step("r_mul",      1, 4'b0000, 4'b0001, 3'b000, v(0,0,1,1,2'b00,0,4'b0100,0,0,0));
    step("r_div",      1, 4'b0000, 4'b0010, 3'b000, v(0,0,1,1,2'b00,0,4'b0101,0,0,0));
    step("r_and",      1, 4'b0000, 4'b1101, 3'b000, v(0,0,1,0,2'b00,0,4'b0010,0,0,0));
    step("r_rotl",     1, 4'b0000, 4'b1000, 3'b000, v(0,0,1,0,2'b00,0,4'b0110,0,0,0));
    step("r_shr",      1, 4'b0000, 4'b1011, 3'b000, v(0,0,1,0,2'b00,0,4'b1001,0,0,0));
    step("lw",         1, 4'b1000, 4'b0000, 3'b000, v(0,0,1,0,2'b00,0,4'b0000,0,1,1));
    step("sw",         1, 4'b1011, 4'b0000, 3'b000, v(0,0,0,0,2'b00,1,4'b0000,0,1,0));
    step("addi",       1, 4'b1100, 4'b0000, 3'b000, v(0,0,1,0,2'b00,0,4'b0000,0,1,0));
    step("bgt",        1, 4'b0100, 4'b0000, 3'b000, v(0,0,0,0,2'b11,0,4'b0001,1,0,0));
    step("blt",        1, 4'b0101, 4'b0000, 3'b000, v(0,0,0,0,2'b10,0,4'b0001,1,0,0));
    step("beq",        1, 4'b0110, 4'b0000, 3'b000, v(0,0,0,0,2'b01,0,4'b0001,1,0,0));
    step("jmp",        1, 4'b0001, 4'b0000, 3'b000, v(1,0,0,0,2'b00,0,4'b0000,0,0,0));

    // Illegal function code: immediate halt, then sticky.
    step("ill_func",   1, 4'b0000, 4'b0111, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,0,0));
    step("stick_add",  1, 4'b0000, 4'b1111, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,0,0));
    step("stick_sw",   1, 4'b1011, 4'b0000, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,1,0));
    step("stick_beq",  1, 4'b0110, 4'b0000, 3'b000, v(0,1,0,0,2'b00,0,4'b0001,1,0,0));
    step("rst_clear",  0, 4'b0000, 4'b1111, 3'b000, v(0,0,0,0,2'b00,0,4'b0000,0,0,0));
    step("after_rst",  1, 4'b0000, 4'b1111, 3'b000, v(0,0,1,0,2'b00,0,4'b0000,0,0,0));

    // Illegal opcode.
    step("ill_op",     1, 4'b0011, 4'b0000, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,0,0));
    step("stick_jmp",  1, 4'b0001, 4'b0000, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,0,0));
    step("rst2",       0, 4'b0001, 4'b0000, 3'b000, v(0,0,0,0,2'b00,0,4'b0000,0,0,0));
    step("jmp_ok",     1, 4'b0001, 4'b0000, 3'b000, v(1,0,0,0,2'b00,0,4'b0000,0,0,0));

    // Each exception pulsed for one cycle under a valid R-type and.
    for (int unsigned e = 0; e < 3; e++) begin
      logic [2:0] exc;
      exc = 3'b100 >> e;
      step($sformatf("exc%0d_pulse", e), 1, 4'b0000, 4'b1101, exc,
           v(0,1,0,0,2'b00,0,4'b0010,0,0,0));
      step($sformatf("exc%0d_sticky", e), 1, 4'b0000, 4'b1101, 3'b000,
           v(0,1,0,0,2'b00,0,4'b0010,0,0,0));
      step($sformatf("exc%0d_rst", e), 0, 4'b0000, 4'b1101, 3'b000,
           v(0,0,0,0,2'b00,0,4'b0010,0,0,0));
      step($sformatf("exc%0d_clear", e), 1, 4'b0000, 4'b1101, 3'b000,
           v(0,0,1,0,2'b00,0,4'b0010,0,0,0));
    end

    // hlt during reset: reset wins, halted_q must not be set.
    step("hlt_in_rst", 0, 4'b1111, 4'b0000, 3'b000, v(0,0,0,0,2'b00,0,4'b0000,0,0,0));
    step("hlt_release",1, 4'b1111, 4'b0000, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,0,0));
    step("rst3",       0, 4'b1111, 4'b0000, 3'b000, v(0,0,0,0,2'b00,0,4'b0000,0,0,0));
    step("q_cleared",  1, 4'b1000, 4'b0000, 3'b000, v(0,0,1,0,2'b00,0,4'b0000,0,1,1));
    step("hlt",        1, 4'b1111, 4'b0000, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,0,0));
    step("hlt_sticky", 1, 4'b1000, 4'b0000, 3'b000, v(0,1,0,0,2'b00,0,4'b0000,0,1,1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
